// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared types and helpers for the PISO serializer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer_if
// Description : Valid/ready word handoff from the producer into the serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;

  modport master (output data_i, output valid_i, input  ready_o);
  modport slave  (input  data_i, input  valid_i, output ready_o);
endinterface
`default_nettype wire

// File: rtl/piso_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : piso_hold_buf
// Description : One-entry holding buffer; ready while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_hold_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             ready_o
);
  import piso_pkg::*;

  logic [WIDTH-1:0] r_hb;
  logic             r_hb_full;

  // A write needs ready (empty) and a read needs full, so they never coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hb      <= '0;
      r_hb_full <= 1'b0;
    end else if (wr_i) begin
      r_hb      <= data_i;
      r_hb_full <= 1'b1;
    end else if (rd_i) begin
      r_hb_full <= 1'b0;
    end
  end

  assign data_o  = r_hb;
  assign full_o  = r_hb_full;
  assign ready_o = !r_hb_full;

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : WIDTH-bit parallel-in, LSB-first serial-out with gapless reload.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  piso_serializer_if.slave        bus,
  output logic                    serial_o,
  output logic                    active_o,
  output logic                    first_o,
  output logic                    last_o
);
  import piso_pkg::*;

  localparam int                 c_cnt_w    = cnt_w(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  piso_state_t        r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_sr, w_sr_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;

  logic               w_xfer;
  logic               w_hb_wr;
  logic               w_hb_rd;
  logic [WIDTH-1:0]   w_hb_data;
  logic               w_hb_full;
  logic               w_ready;

  piso_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_i    (w_hb_wr),
    .rd_i    (w_hb_rd),
    .data_i  (bus.data_i),
    .data_o  (w_hb_data),
    .full_o  (w_hb_full),
    .ready_o (w_ready)
  );

  assign bus.ready_o = w_ready;
  assign w_xfer      = bus.valid_i && w_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_hb_wr     = 1'b0;
    w_hb_rd     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_sr_nxt    = bus.data_i;
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt != c_cnt_last) begin
          w_sr_nxt  = r_sr >> 1;
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
          w_hb_wr   = w_xfer;
        end else if (w_hb_full) begin
          w_sr_nxt  = w_hb_data;
          w_cnt_nxt = '0;
          w_hb_rd   = 1'b1;
        end else if (w_xfer) begin
          // Word arriving on the last bit skips the buffer to avoid a gap.
          w_sr_nxt  = bus.data_i;
          w_cnt_nxt = '0;
        end else begin
          w_sr_nxt    = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign active_o = (r_state == SHIFT);
  assign serial_o = active_o && r_sr[0];
  assign first_o  = active_o && (r_cnt == '0);
  assign last_o   = active_o && (r_cnt == c_cnt_last);

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Directed bench for piso_serializer with a 4-bit SIPO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  localparam int WIDTH = 4;

  logic clk_i;
  logic rst_ni;
  logic serial_o, active_o, first_o, last_o;
  logic [3:0] r_sipo;

  int n_vec;
  int n_err;

  piso_serializer_if #(.WIDTH(WIDTH)) bus ();

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .bus      (bus.slave),
    .serial_o (serial_o),
    .active_o (active_o),
    .first_o  (first_o),
    .last_o   (last_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Downstream right-shifting SIPO: incoming bit enters at the MSB.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_sipo <= '0;
    else if (active_o) r_sipo <= {serial_o, r_sipo[3:1]};
  end

  // Observation vector: {ready, serial, active, first, last}
  function automatic logic [4:0] obs();
    return {bus.ready_o, serial_o, active_o, first_o, last_o};
  endfunction

  task automatic test_reset();
    logic [4:0] got;
    rst_ni = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    repeat (3) begin
      @(negedge clk_i);
      got = obs();
      n_vec++;
      if (got !== 5'b10000) begin
        n_err++;
        $display("FAIL reset_asserted got=%b exp=%b", got, 5'b10000);
      end
    end
    rst_ni = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      got = obs();
      n_vec++;
      if (got !== 5'b10000) begin
        n_err++;
        $display("FAIL reset_idle got=%b exp=%b", got, 5'b10000);
      end
    end
  endtask

  // Runs cycles 1..9 after a word accepted on edge 0; second word offered on edge `v2_edge`.
  task automatic run_two(input logic [3:0] w1, input logic [3:0] w2, input int v2_edge,
                         input logic [8:0] exp_ser, input logic [8:0] exp_rdy,
                         input logic [8:0] exp_first, input logic [8:0] exp_last,
                         input logic [8:0] exp_act, input string name);
    logic [4:0] got, exp;
    @(posedge clk_i); #1;
    bus.valid_i = 1'b1;
    bus.data_i  = w1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(posedge clk_i); #1;
      bus.valid_i = (cyc == v2_edge);
      bus.data_i  = (cyc == v2_edge) ? w2 : 4'h0;
      @(negedge clk_i);
      got = obs();
      exp = {exp_rdy[cyc-1], exp_ser[cyc-1], exp_act[cyc-1], exp_first[cyc-1], exp_last[cyc-1]};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s cycle=%0d got=%b exp=%b", name, cyc, got, exp);
      end
      if (cyc == 5) begin
        n_vec++;
        if (r_sipo !== w1) begin
          n_err++;
          $display("FAIL %s sipo_word1 got=%h exp=%h", name, r_sipo, w1);
        end
      end
      if (cyc == 9) begin
        n_vec++;
        if (r_sipo !== w2) begin
          n_err++;
          $display("FAIL %s sipo_word2 got=%h exp=%h", name, r_sipo, w2);
        end
      end
    end
  endtask

  task automatic test_single_word();
    logic [4:0] got, exp;
    logic [3:0] bits;
    bits = 4'b1011;
    @(posedge clk_i); #1;
    bus.valid_i = 1'b1;
    bus.data_i  = bits;
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk_i);
      got = obs();
      exp = (cyc <= 4) ? {1'b1, bits[cyc-1], 1'b1, (cyc == 1), (cyc == 4)} : 5'b10000;
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL single_word cycle=%0d got=%b exp=%b", cyc, got, exp);
      end
    end
    n_vec++;
    if (r_sipo !== 4'hB) begin
      n_err++;
      $display("FAIL single_word_sipo got=%h exp=%h", r_sipo, 4'hB);
    end
  endtask

  // Bit vectors below are indexed by cycle-1 (bit 0 = cycle 1).
  task automatic test_back_to_back();
    // serial 0,1,0,1,1,0,1,0,0 ; ready low in cycles 3,4
    run_two(4'hA, 4'h5, 2,
            9'b0_0101_1010, 9'b1_1111_0011,
            9'b0_0001_0001, 9'b0_1000_1000, 9'b0_1111_1111, "back_to_back");
  endtask

  task automatic test_bypass();
    // serial 0,0,1,1,1,1,0,0,0 ; ready stays high throughout
    run_two(4'hC, 4'h3, 4,
            9'b0_0011_1100, 9'b1_1111_1111,
            9'b0_0001_0001, 9'b0_1000_1000, 9'b0_1111_1111, "bypass");
  endtask

  task automatic test_reset_mid();
    logic [4:0] got;
    @(posedge clk_i); #1;
    bus.valid_i = 1'b1;
    bus.data_i  = 4'hF;
    @(posedge clk_i); #1;
    bus.data_i  = 4'h9;
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
    bus.data_i  = 4'h0;
    @(negedge clk_i);
    got = obs();
    n_vec++;
    if (got !== 5'b01100) begin
      n_err++;
      $display("FAIL reset_mid_buffered got=%b exp=%b", got, 5'b01100);
    end
    // Bit 2 of 0xF is on the wire after the next edge; reset lands mid-cycle.
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    got = obs();
    n_vec++;
    if (got !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_mid_async got=%b exp=%b", got, 5'b10000);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (6) begin
      @(negedge clk_i);
      got = obs();
      n_vec++;
      if (got !== 5'b10000) begin
        n_err++;
        $display("FAIL reset_mid_after got=%b exp=%b", got, 5'b10000);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
